memoria_parametrica: RTL and testbench
======================================

# memoria_parametrica

Parametrised dual-port message buffer for the mining datapath: holds the message being hashed and feeds it to the SHA message scheduler. Generalises the fixed 8-bit × 512-entry message memory with configurable word width and depth, and adds a sequential (auto-pointer) mode with occupancy tracking, read-valid signalling and a restart command. It sits between the message loader (writer) and the hash core (reader).

## Interface

Parameters:
- DATA_WIDTH, 8, word width in bits
- DATA_DEPTH, 512, number of words; must be a power of two, ≥ 2
- ADDR_WIDTH, $clog2(DATA_DEPTH), address width (derived; not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- modo  in  1  0 = random access (external addresses), 1 = sequential (internal pointers)
- clear  in  1  restart pulse: pointers, count and flags to 0; RAM untouched
- we  in  1  write request
- re  in  1  read request
- indirizzo_write  in  ADDR_WIDTH  write address (used only when modo = 0)
- indirizzo_read  in  ADDR_WIDTH  read address (used only when modo = 0)
- dati  in  DATA_WIDTH  write data
- out_mem  out  DATA_WIDTH  read data, registered
- out_valid  out  1  high for one cycle when out_mem carries a new word
- conteggio  out  ADDR_WIDTH+1  words currently written and not yet read (sequential mode)
- fine_scrittura  out  1  sticky: last entry written
- fine_lettura  out  1  sticky: last entry read

## Operation

- Reset (reset = 0 at an edge): out_mem = 0, out_valid = 0, conteggio = 0, fine_scrittura = 0, fine_lettura = 0, wr_ptr = rd_ptr = 0. RAM contents not cleared. Reset mid-operation discards any in-flight read (out_valid stays 0).
- clear: same effect as reset on pointers, conteggio, flags and out_valid; out_mem holds its value. clear has priority over we/re in the same cycle (both ignored).
- Random mode (modo = 0): every we writes dati to ram[indirizzo_write]; every re reads ram[indirizzo_read]. fine_scrittura set on a write to DATA_DEPTH-1; fine_lettura set on a read of DATA_DEPTH-1. Pointers and conteggio frozen.
- Sequential mode (modo = 1):
  - Write accepted iff we and wr_ptr has not wrapped past full (conteggio < DATA_DEPTH and fine_scrittura = 0); writes ram[wr_ptr], wr_ptr+1.
  - Read accepted iff re and conteggio > 0 (counting a same-cycle write as not yet visible); reads ram[rd_ptr], rd_ptr+1.
  - Rejected requests have no side effects; out_valid stays 0.
  - fine_scrittura set when the write to entry DATA_DEPTH-1 is accepted; further writes rejected until clear/reset (no wrap).
  - fine_lettura set when the read of entry DATA_DEPTH-1 is accepted.
  - conteggio: +1 on write-only, −1 on read-only, unchanged on simultaneous accepted read and write.
- Same-address read and write in one cycle: read returns the old content (read-before-write).
- Changing modo is legal only after clear; pointers are not re-derived.

## Timing

- Write: RAM updated at the accepting edge; readable from the next cycle.
- Read latency 1 cycle: accepted read at edge N → out_mem valid and out_valid = 1 after edge N+1... i.e. registered at edge N, visible cycle N+1.
- out_mem holds last read value when no read accepted; out_valid deasserts the following cycle.
- Flags and conteggio register at the same edge as the accepting access.
- Sustained throughput: one write and one read per cycle.

## Structure

- Shared package mining_pkg: constants MODO_CASUALE = 1'b0, MODO_SEQUENZIALE = 1'b1.
- Sub-module ram_dp: plain simple-dual-port RAM (one write port, one registered read port, read-before-write), parametrised by DATA_WIDTH/DATA_DEPTH; memoria_parametrica holds pointers, counter, flags and valid logic.

## Test plan

- Random mode, defaults: write 0x00..0xFF pattern (addr & 0xFF) to all 512 addresses → fine_scrittura rises on the write to 511; read 511 → out_mem = 0xFF one cycle later, fine_lettura = 1.
- Sequential, DATA_WIDTH = 32, DATA_DEPTH = 16: write 16 words 0xA0000000+i → conteggio = 16, fine_scrittura = 1; 17th write rejected, conteggio stays 16.
- Sequential empty read: re with conteggio = 0 → out_valid stays 0, rd_ptr unchanged; write 0x5A then re next cycle → out_mem = 0x5A, out_valid pulse.
- Simultaneous read and write with conteggio = 3 → conteggio stays 3, data order preserved (FIFO order checked against model).
- clear asserted together with we/re at conteggio = 5 → conteggio = 0, flags 0, no write; reset = 0 mid-burst → all outputs 0, next accepted write lands at entry 0.
- Same-address read/write in random mode (addr 7, old 0x11, new 0x22) → out_mem = 0x11; read again next cycle → 0x22.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared constants for the mining datapath blocks.
package mining_pkg;

  localparam logic MODO_CASUALE     = 1'b0;
  localparam logic MODO_SEQUENZIALE = 1'b1;

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module ram_dp #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DATA_DEPTH = 512,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register only: reset clears it, a disabled read holds the last word.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/memoria_parametrica.sv
// Message buffer feeding the SHA scheduler: random-access or sequential (FIFO-like)
// access over a dual-port RAM, with occupancy count, read-valid and sticky end flags.
module memoria_parametrica
  import mining_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DATA_DEPTH = 512,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  modo,
  input  logic                  clear,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] indirizzo_write,
  input  logic [ADDR_WIDTH-1:0] indirizzo_read,
  input  logic [DATA_WIDTH-1:0] dati,
  output logic [DATA_WIDTH-1:0] out_mem,
  output logic                  out_valid,
  output logic [ADDR_WIDTH:0]   conteggio,
  output logic                  fine_scrittura,
  output logic                  fine_lettura
);

  localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  fine_w_q, fine_w_d;
  logic                  fine_r_q, fine_r_d;
  logic                  valid_q, valid_d;

  logic                  seq;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign seq     = (modo == MODO_SEQUENZIALE);
  assign wr_addr = seq ? wr_ptr_q : indirizzo_write;
  assign rd_addr = seq ? rd_ptr_q : indirizzo_read;

  // Reset and clear both suppress every access in their cycle. A sequential read
  // only sees words already counted, so a same-cycle write cannot feed it.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    if (reset && !clear) begin
      if (seq) begin
        wr_acc = we && (count_q < FULL) && !fine_w_q;
        rd_acc = re && (count_q != '0);
      end else begin
        wr_acc = we;
        rd_acc = re;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fine_w_d = fine_w_q;
    fine_r_d = fine_r_q;
    valid_d  = rd_acc;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      fine_w_d = 1'b0;
      fine_r_d = 1'b0;
      valid_d  = 1'b0;
    end else begin
      if (wr_acc && (wr_addr == LAST)) fine_w_d = 1'b1;
      if (rd_acc && (rd_addr == LAST)) fine_r_d = 1'b1;
      if (seq) begin
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fine_w_q <= 1'b0;
      fine_r_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fine_w_q <= fine_w_d;
      fine_r_q <= fine_r_d;
      valid_q  <= valid_d;
    end
  end

  ram_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH)
  ) u_ram (
    .clk      (clk),
    .rst_n_i  (reset),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_addr),
    .wr_data_i(dati),
    .rd_en_i  (rd_acc),
    .rd_addr_i(rd_addr),
    .rd_data_o(out_mem)
  );

  assign out_valid      = valid_q;
  assign conteggio      = count_q;
  assign fine_scrittura = fine_w_q;
  assign fine_lettura   = fine_r_q;

endmodule

// File: tb/tb_memoria_parametrica.sv
// Bench: default-size instance for random access, 32x16 instance for sequential mode.
module tb_memoria_parametrica;
  import mining_pkg::*;

  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8 x 512
  logic       reset_a, modo_a, clear_a, we_a, re_a;
  logic [8:0] wa_a, ra_a;
  logic [7:0] dati_a, out_a;
  logic       valid_a, fw_a, fl_a;
  logic [9:0] cnt_a;

  // Instance B: 32 x 16
  logic        reset_b, modo_b, clear_b, we_b, re_b;
  logic [3:0]  wa_b, ra_b;
  logic [31:0] dati_b, out_b;
  logic        valid_b, fw_b, fl_b;
  logic [4:0]  cnt_b;

  memoria_parametrica dut_a (
    .clk(clk), .reset(reset_a), .modo(modo_a), .clear(clear_a), .we(we_a), .re(re_a),
    .indirizzo_write(wa_a), .indirizzo_read(ra_a), .dati(dati_a), .out_mem(out_a),
    .out_valid(valid_a), .conteggio(cnt_a), .fine_scrittura(fw_a), .fine_lettura(fl_a)
  );

  memoria_parametrica #(.DATA_WIDTH(32), .DATA_DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset_b), .modo(modo_b), .clear(clear_b), .we(we_b), .re(re_b),
    .indirizzo_write(wa_b), .indirizzo_read(ra_b), .dati(dati_b), .out_mem(out_b),
    .out_valid(valid_b), .conteggio(cnt_b), .fine_scrittura(fw_b), .fine_lettura(fl_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model A: plain memory array plus expected outputs.
  logic [7:0] ram_a [512];
  logic [7:0] exp_out_a = '0;
  logic       exp_valid_a = 1'b0, exp_fw_a = 1'b0, exp_fl_a = 1'b0;

  // Reference model B: memory image plus a queue of unread words.
  logic [31:0] ram_b [DEPTH_B];
  logic [31:0] fifo_b [$];
  int          wcnt_b = 0, rcnt_b = 0;
  logic [31:0] exp_out_b = '0;
  logic        exp_valid_b = 1'b0, exp_fw_b = 1'b0, exp_fl_b = 1'b0;
  logic [4:0]  exp_cnt_b = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cycle(input bit w, input logic [8:0] wa, input logic [7:0] d,
                         input bit r, input logic [8:0] ra);
    modo_a = MODO_CASUALE; clear_a = 1'b0;
    we_a = w; wa_a = wa; dati_a = d; re_a = r; ra_a = ra;
    exp_valid_a = r;
    if (r) begin
      exp_out_a = ram_a[ra];
      if (ra == 9'd511) exp_fl_a = 1'b1;
    end
    if (w) begin
      ram_a[wa] = d;
      if (wa == 9'd511) exp_fw_a = 1'b1;
    end
    tick();
    we_a = 1'b0; re_a = 1'b0;
  endtask

  task automatic b_cycle(input bit w, input logic [31:0] d, input bit r);
    modo_b = MODO_SEQUENZIALE; clear_b = 1'b0;
    we_b = w; re_b = r; dati_b = d;
    exp_valid_b = 1'b0;
    if (r && fifo_b.size() > 0) begin
      exp_out_b = fifo_b.pop_front();
      exp_valid_b = 1'b1;
      rcnt_b++;
      if (rcnt_b == DEPTH_B) exp_fl_b = 1'b1;
    end
    if (w && wcnt_b < DEPTH_B) begin
      ram_b[wcnt_b] = d;
      fifo_b.push_back(d);
      wcnt_b++;
      if (wcnt_b == DEPTH_B) exp_fw_b = 1'b1;
    end
    exp_cnt_b = 5'(fifo_b.size());
    tick();
    we_b = 1'b0; re_b = 1'b0;
  endtask

  task automatic b_model_restart();
    fifo_b.delete();
    wcnt_b = 0; rcnt_b = 0;
    exp_fw_b = 1'b0; exp_fl_b = 1'b0; exp_valid_b = 1'b0; exp_cnt_b = '0;
  endtask

  task automatic b_clear(input bit w, input bit r, input logic [31:0] d);
    modo_b = MODO_SEQUENZIALE; clear_b = 1'b1; we_b = w; re_b = r; dati_b = d;
    tick();
    clear_b = 1'b0; we_b = 1'b0; re_b = 1'b0;
    b_model_restart();
  endtask

  task automatic b_reset(input bit w, input bit r, input logic [31:0] d);
    reset_b = 1'b0; we_b = w; re_b = r; dati_b = d;
    tick();
    reset_b = 1'b1; we_b = 1'b0; re_b = 1'b0;
    b_model_restart();
    exp_out_b = '0;
  endtask

  task automatic b_rand_read(input logic [3:0] addr);
    modo_b = MODO_CASUALE; clear_b = 1'b0; we_b = 1'b0; re_b = 1'b1; ra_b = addr;
    exp_out_b = ram_b[addr];
    exp_valid_b = 1'b1;
    tick();
    re_b = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({out_a, valid_a, cnt_a, fw_a, fl_a} !== 21'd0) begin
      fails++;
      $display("FAIL reset_a got out=%h v=%b cnt=%0d fw=%b fl=%b exp all 0", out_a, valid_a, cnt_a, fw_a, fl_a);
    end
    tests++;
    if ({out_b, valid_b, cnt_b, fw_b, fl_b} !== 40'd0) begin
      fails++;
      $display("FAIL reset_b got out=%h v=%b cnt=%0d fw=%b fl=%b exp all 0", out_b, valid_b, cnt_b, fw_b, fl_b);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_random_fill();
    for (int i = 0; i < 512; i++) begin
      a_cycle(1'b1, 9'(i), 8'(i & 'hFF), 1'b0, 9'd0);
      if (i == 510 || i == 511) begin
        tests++;
        if (fw_a !== exp_fw_a) begin
          fails++;
          $display("FAIL fill_fw addr=%0d got %b exp %b", i, fw_a, exp_fw_a);
        end
      end
    end
    a_cycle(1'b0, 9'd0, 8'd0, 1'b1, 9'd511);
    tests++;
    if (out_a !== 8'hFF || valid_a !== 1'b1 || fl_a !== 1'b1) begin
      fails++;
      $display("FAIL read511 got out=%h v=%b fl=%b exp out=ff v=1 fl=1", out_a, valid_a, fl_a);
    end
    a_cycle(1'b0, 9'd0, 8'd0, 1'b0, 9'd0);
    tests++;
    if (out_a !== 8'hFF || valid_a !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold got out=%h v=%b exp out=ff v=0", out_a, valid_a);
    end
    $display("[TB] random fill done");
  endtask

  task automatic test_random_access();
    for (int n = 0; n < 200; n++) begin
      a_cycle(1'($urandom_range(1)), 9'($urandom), 8'($urandom),
              1'($urandom_range(1)), 9'($urandom));
      tests++;
      if ({out_a, valid_a, cnt_a, fw_a, fl_a} !== {exp_out_a, exp_valid_a, 10'd0, exp_fw_a, exp_fl_a}) begin
        fails++;
        $display("FAIL rand_a n=%0d got out=%h v=%b cnt=%0d exp out=%h v=%b cnt=0",
                 n, out_a, valid_a, cnt_a, exp_out_a, exp_valid_a);
      end
    end
    $display("[TB] random access done");
  endtask

  task automatic test_same_addr();
    a_cycle(1'b1, 9'd7, 8'h11, 1'b0, 9'd0);
    a_cycle(1'b1, 9'd7, 8'h22, 1'b1, 9'd7);
    tests++;
    if (out_a !== 8'h11) begin
      fails++;
      $display("FAIL rbw_old got %h exp 11", out_a);
    end
    a_cycle(1'b0, 9'd0, 8'd0, 1'b1, 9'd7);
    tests++;
    if (out_a !== 8'h22) begin
      fails++;
      $display("FAIL rbw_new got %h exp 22", out_a);
    end
    $display("[TB] same-address read/write done");
  endtask

  task automatic test_seq_full();
    b_clear(1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH_B; i++) begin
      b_cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
      if (i == DEPTH_B - 2) begin
        tests++;
        if (fw_b !== 1'b0) begin
          fails++;
          $display("FAIL fw_early got %b exp 0", fw_b);
        end
      end
    end
    tests++;
    if (cnt_b !== 5'd16 || fw_b !== 1'b1) begin
      fails++;
      $display("FAIL seq_full got cnt=%0d fw=%b exp cnt=16 fw=1", cnt_b, fw_b);
    end
    b_cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    tests++;
    if (cnt_b !== 5'd16 || valid_b !== 1'b0) begin
      fails++;
      $display("FAIL write17 got cnt=%0d v=%b exp cnt=16 v=0", cnt_b, valid_b);
    end
    for (int i = 0; i < DEPTH_B; i++) begin
      b_cycle(1'b0, '0, 1'b1);
      tests++;
      if (out_b !== 32'hA000_0000 + 32'(i) || valid_b !== 1'b1) begin
        fails++;
        $display("FAIL drain i=%0d got %h v=%b exp %h v=1", i, out_b, valid_b, 32'hA000_0000 + 32'(i));
      end
    end
    tests++;
    if (cnt_b !== 5'd0 || fl_b !== 1'b1) begin
      fails++;
      $display("FAIL drained got cnt=%0d fl=%b exp cnt=0 fl=1", cnt_b, fl_b);
    end
    $display("[TB] sequential full/drain done");
  endtask

  task automatic test_empty_read();
    b_clear(1'b0, 1'b0, '0);
    b_cycle(1'b0, '0, 1'b1);
    tests++;
    if (valid_b !== 1'b0 || cnt_b !== 5'd0) begin
      fails++;
      $display("FAIL empty_read got v=%b cnt=%0d exp v=0 cnt=0", valid_b, cnt_b);
    end
    b_cycle(1'b1, 32'h5A, 1'b0);
    b_cycle(1'b0, '0, 1'b1);
    tests++;
    if (out_b !== 32'h5A || valid_b !== 1'b1) begin
      fails++;
      $display("FAIL read_5a got %h v=%b exp 5a v=1", out_b, valid_b);
    end
    b_cycle(1'b0, '0, 1'b0);
    tests++;
    if (valid_b !== 1'b0 || out_b !== 32'h5A) begin
      fails++;
      $display("FAIL valid_pulse got v=%b out=%h exp v=0 out=5a", valid_b, out_b);
    end
    $display("[TB] empty read done");
  endtask

  task automatic test_back_to_back();
    b_clear(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) b_cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      b_cycle(1'b1, $urandom, 1'b1);
      tests++;
      if (cnt_b !== 5'd3 || valid_b !== 1'b1 || out_b !== exp_out_b) begin
        fails++;
        $display("FAIL b2b i=%0d got cnt=%0d v=%b out=%h exp cnt=3 v=1 out=%h", i, cnt_b, valid_b, out_b, exp_out_b);
      end
    end
    $display("[TB] back-to-back done");
  endtask

  task automatic test_clear_priority();
    b_clear(1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) b_cycle(1'b1, 32'h1000 + 32'(i), 1'b0);
    b_clear(1'b1, 1'b1, 32'hBAD0_BAD0);
    tests++;
    if ({cnt_b, fw_b, fl_b, valid_b} !== 8'd0 || out_b !== exp_out_b) begin
      fails++;
      $display("FAIL clear_prio got cnt=%0d fw=%b fl=%b v=%b out=%h exp 0 out=%h",
               cnt_b, fw_b, fl_b, valid_b, out_b, exp_out_b);
    end
    b_rand_read(4'd5);
    tests++;
    if (out_b !== exp_out_b || out_b === 32'hBAD0_BAD0) begin
      fails++;
      $display("FAIL clear_nowrite got %h exp %h", out_b, exp_out_b);
    end
    b_clear(1'b0, 1'b0, '0);
    $display("[TB] clear priority done");
  endtask

  task automatic test_reset_mid_burst();
    b_clear(1'b0, 1'b0, '0);
    b_cycle(1'b1, 32'h3333_0000, 1'b0);
    b_cycle(1'b1, 32'h3333_0001, 1'b0);
    b_cycle(1'b1, 32'h3333_0002, 1'b1);
    b_reset(1'b1, 1'b1, 32'hCAFE_0000);
    tests++;
    if ({out_b, valid_b, cnt_b, fw_b, fl_b} !== 40'd0) begin
      fails++;
      $display("FAIL mid_reset got out=%h v=%b cnt=%0d fw=%b fl=%b exp all 0", out_b, valid_b, cnt_b, fw_b, fl_b);
    end
    b_cycle(1'b1, 32'h7777_7777, 1'b0);
    b_clear(1'b0, 1'b0, '0);
    b_rand_read(4'd0);
    tests++;
    if (out_b !== 32'h7777_7777) begin
      fails++;
      $display("FAIL after_reset_entry0 got %h exp 77777777", out_b);
    end
    b_clear(1'b0, 1'b0, '0);
    $display("[TB] reset mid-burst done");
  endtask

  task automatic test_random_seq();
    b_clear(1'b0, 1'b0, '0);
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 49) begin
        b_clear(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
      end else begin
        b_cycle($urandom_range(9) < 6, $urandom, $urandom_range(1) == 1);
      end
      tests++;
      if ({valid_b, cnt_b, fw_b, fl_b} !== {exp_valid_b, exp_cnt_b, exp_fw_b, exp_fl_b} || out_b !== exp_out_b) begin
        fails++;
        $display("FAIL rand_seq n=%0d got v=%b cnt=%0d fw=%b fl=%b out=%h exp v=%b cnt=%0d fw=%b fl=%b out=%h",
                 n, valid_b, cnt_b, fw_b, fl_b, out_b, exp_valid_b, exp_cnt_b, exp_fw_b, exp_fl_b, exp_out_b);
      end
    end
    $display("[TB] random sequential done");
  endtask

  initial begin
    reset_a = 1'b0; modo_a = MODO_CASUALE; clear_a = 1'b0; we_a = 1'b0; re_a = 1'b0;
    wa_a = '0; ra_a = '0; dati_a = '0;
    reset_b = 1'b0; modo_b = MODO_SEQUENZIALE; clear_b = 1'b0; we_b = 1'b0; re_b = 1'b0;
    wa_b = '0; ra_b = '0; dati_b = '0;
    tick();
    tick();
    test_reset();
    reset_a = 1'b1;
    reset_b = 1'b1;
    test_random_fill();
    test_random_access();
    test_same_addr();
    test_seq_full();
    test_empty_read();
    test_back_to_back();
    test_clear_priority();
    test_reset_mid_burst();
    test_random_seq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
